// File: rtl/io_uart_responder_if.sv
// Byte-wide I/O handshake between the CPU-side controller (master) and the UART responder (slave).
// Reads are level requests answered by a one-cycle done pulse; writes are one-cycle pulses gated by ready.
interface io_uart_responder_if;
    logic       io_read_req;
    logic       io_write_req;
    logic [7:0] io_wdata;
    logic       io_ready;
    logic       io_done;
    logic [7:0] io_rdata;

    modport master (
        output io_read_req, io_write_req, io_wdata,
        input  io_ready, io_done, io_rdata
    );

    modport slave (
        input  io_read_req, io_write_req, io_wdata,
        output io_ready, io_done, io_rdata
    );
endinterface

// File: rtl/io_uart_responder.sv
// UART peripheral for the CPU byte I/O handshake: writes become 8N1 frames, received frames are FIFO'd for reads.
// Latency: write->start bit 2 cycles, read->done 1 cycle; backpressure via io_ready (one-byte holding register).
module io_uart_responder #(
    parameter int CLK_PER_BIT = 868,
    parameter int RX_DEPTH    = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    io_uart_responder_if.slave io,
    input  logic               uart_rxd,
    output logic               uart_txd,
    input  logic               err_clear,
    output logic               rx_overflow,
    output logic               rx_frame_err,
    output logic               tx_overrun
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int AW    = $clog2(RX_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLK_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- write path / holding register ----------------
    logic       hold_full;
    logic [7:0] hold_dat;
    logic       tx_load;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hold_full <= 1'b0;
            hold_dat  <= 8'h00;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end else if (io.io_write_req && !hold_full) begin
            hold_full <= 1'b1;
            hold_dat  <= io.io_wdata;
        end
    end

    assign io.io_ready = ~hold_full;

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             txd_q, txd_n;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd_q    <= txd_n;
        end
    end

    // txd is registered so the line level changes exactly on bit-period boundaries
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + CNT_ONE;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd_q;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (hold_full) begin
                    tx_load    = 1'b1;
                    tx_shift_n = hold_dat;
                    txd_n      = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                    txd_n      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        txd_n      = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    // a refilled holding register chains straight into the next start bit
                    if (hold_full) begin
                        tx_load    = 1'b1;
                        tx_shift_n = hold_dat;
                        txd_n      = 1'b0;
                        tx_state_n = TX_START;
                    end else begin
                        txd_n      = 1'b1;
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign uart_txd = txd_q;

    // ---------------- RX synchronizer ----------------
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx_s;
    logic       rx_fall;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_stop_ok;
    logic             rx_stop_bad;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // The edge-detect cycle counts as cycle 0 of the start bit, so samples land mid-bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = (rx_cnt == BIT_LAST) ? '0 : rx_cnt + CNT_ONE;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = rx_fall ? CNT_ONE : '0;
                if (rx_fall) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_stop_ok  = rx_s;
                    rx_stop_bad = ~rx_s;
                    rx_state_n  = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    logic       rx_push_q;
    logic [7:0] rx_byte_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_push_q <= 1'b0;
            rx_byte_q <= 8'h00;
        end else begin
            rx_push_q <= rx_stop_ok;
            if (rx_stop_ok) rx_byte_q <= rx_shift;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push_vld, pop_vld;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_vld   = rx_push_q & ~fifo_full;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_vld) fifo_mem[wr_ptr[AW-1:0]] <= rx_byte_q;
    end

    // ---------------- read path ----------------
    logic       done_q;
    logic [7:0] rdata_q;

    // ~done_q keeps a request that is still high during the done cycle from popping a second byte
    assign pop_vld = io.io_read_req & ~done_q & ~fifo_empty;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            done_q <= pop_vld;
            if (pop_vld) rdata_q <= fifo_mem[rd_ptr[AW-1:0]];
        end
    end

    assign io.io_done  = done_q;
    assign io.io_rdata = rdata_q;

    // ---------------- sticky errors ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overrun   <= 1'b0;
        end else begin
            rx_overflow  <= (rx_overflow  & ~err_clear) | (rx_push_q & fifo_full);
            rx_frame_err <= (rx_frame_err & ~err_clear) | rx_stop_bad;
            tx_overrun   <= (tx_overrun   & ~err_clear) | (io.io_write_req & hold_full);
        end
    end

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed bench for io_uart_responder with CLK_PER_BIT=4, RX_DEPTH=4; TX frames and read data are scoreboarded.
module tb_io_uart_responder;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic uart_rxd = 1'b1;
    logic err_clear = 1'b0;
    logic uart_txd;
    logic rx_overflow, rx_frame_err, tx_overrun;

    io_uart_responder_if bus();

    io_uart_responder #(.CLK_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .io           (bus),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd),
        .err_clear    (err_clear),
        .rx_overflow  (rx_overflow),
        .rx_frame_err (rx_frame_err),
        .tx_overrun   (tx_overrun)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int   model_cnt = 0;
    logic exp_ovf   = 1'b0;
    int   tx_frames = 0;
    int   done_cnt  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (CPB) step();
        end
        uart_rxd = 1'b1;
        if (stop) begin
            if (model_cnt < DEPTH) begin
                rx_q.push_back(b);
                model_cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (bus.io_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
    endtask

    // TX frame monitor: every frame is 40 cycles, start low, LSB first, stop high
    initial begin : tx_mon
        logic [7:0] b;
        logic       expb;
        bit         ab;
        forever begin
            @(negedge CLK);
            if (RSTN === 1'b1 && uart_txd === 1'b0) begin
                chk(32'(tx_q.size() > 0), 1, "tx_frame_expected");
                b  = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
                ab = 1'b0;
                for (int i = 0; i < 40 && !ab; i++) begin
                    if (i > 0) @(negedge CLK);
                    if (RSTN !== 1'b1) begin
                        ab = 1'b1;
                    end else begin
                        expb = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b[3'((i - 4) / 4)];
                        chk(32'(uart_txd), 32'(expb), "tx_bit");
                    end
                end
                if (!ab) tx_frames++;
            end
        end
    end

    // Read monitor: each io_done pops the expected byte
    initial begin : rd_mon
        forever begin
            @(negedge CLK);
            if (RSTN === 1'b1) begin
                if (bus.io_done === 1'b1) begin
                    chk(32'(prev_done), 0, "done_back_to_back");
                    chk(32'(rx_q.size() > 0), 1, "done_expected");
                    if (rx_q.size() > 0) chk(32'(bus.io_rdata), 32'(rx_q.pop_front()), "rdata");
                    if (model_cnt > 0) model_cnt--;
                    done_cnt++;
                end
                prev_done = bus.io_done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin : main
        int dc0;
        int fr0;
        bus.io_read_req  = 1'b0;
        bus.io_write_req = 1'b0;
        bus.io_wdata     = 8'h00;

        // reset values
        repeat (3) @(posedge CLK);
        #1;
        chk(32'(bus.io_ready), 1, "rst_ready");
        chk(32'(bus.io_done), 0, "rst_done");
        chk(32'(bus.io_rdata), 0, "rst_rdata");
        chk(32'(uart_txd), 1, "rst_txd");
        chk(32'({rx_overflow, rx_frame_err, tx_overrun}), 0, "rst_errs");
        RSTN = 1'b1;
        step();
        step();

        // single write 0x55
        bus.io_write_req = 1'b1;
        bus.io_wdata     = 8'h55;
        tx_q.push_back(8'h55);
        step();
        bus.io_write_req = 1'b0;
        chk(32'(bus.io_ready), 0, "w1_ready_low");
        chk(32'(uart_txd), 1, "w1_txd_before_start");
        step();
        chk(32'(bus.io_ready), 1, "w1_ready_back");
        chk(32'(uart_txd), 0, "w1_start_bit");
        repeat (45) step();
        chk(tx_frames, 1, "w1_frames");
        chk(32'(uart_txd), 1, "w1_idle_after");

        // back-to-back writes plus an overrun attempt
        bus.io_write_req = 1'b1;
        bus.io_wdata     = 8'hA5;
        tx_q.push_back(8'hA5);
        step();
        bus.io_write_req = 1'b0;
        step();
        step();
        bus.io_write_req = 1'b1;
        bus.io_wdata     = 8'h3C;
        tx_q.push_back(8'h3C);
        step();
        bus.io_write_req = 1'b0;
        chk(32'(bus.io_ready), 0, "b2b_hold_full");
        repeat (6) step();
        bus.io_write_req = 1'b1;
        bus.io_wdata     = 8'hEE;
        step();
        bus.io_write_req = 1'b0;
        chk(32'(tx_overrun), 1, "b2b_overrun");
        repeat (30) step();
        chk(32'(bus.io_ready), 0, "b2b_ready_low_in_stop");
        step();
        chk(32'(bus.io_ready), 1, "b2b_ready_after_stop");
        chk(32'(uart_txd), 0, "b2b_no_gap_start");
        repeat (50) step();
        chk(tx_frames, 3, "b2b_frames");
        chk(tx_q.size(), 0, "b2b_txq_drained");
        pulse_clear();
        chk(32'(tx_overrun), 0, "overrun_cleared");

        // buffered read
        dc0 = done_cnt;
        send_rx(8'h41, 1'b1);
        repeat (6) step();
        bus.io_read_req = 1'b1;
        step();
        chk(32'(bus.io_done), 1, "rd_done");
        chk(32'(bus.io_rdata), 32'h41, "rd_data");
        repeat (8) step();
        chk(done_cnt, dc0 + 1, "rd_single_done");
        bus.io_read_req = 1'b0;
        step();

        // read waiting on data
        dc0 = done_cnt;
        bus.io_read_req = 1'b1;
        repeat (5) step();
        send_rx(8'h7E, 1'b1);
        step();
        chk(32'(bus.io_done), 0, "wait_done_early1");
        step();
        chk(32'(bus.io_done), 0, "wait_done_early2");
        step();
        chk(32'(bus.io_done), 1, "wait_done_pulse");
        chk(32'(bus.io_rdata), 32'h7E, "wait_data");
        bus.io_read_req = 1'b0;
        repeat (4) step();
        chk(done_cnt, dc0 + 1, "wait_single_done");

        // overflow: five frames into a four-entry FIFO
        for (int b = 1; b <= 5; b++) begin
            send_rx(8'(b), 1'b1);
            repeat (2) step();
        end
        repeat (4) step();
        chk(32'(rx_overflow), 32'(exp_ovf), "ovf_flag");
        for (int r = 0; r < 4; r++) begin
            bus.io_read_req = 1'b1;
            wait_done(10);
            chk(32'(bus.io_done), 1, "ovf_read_done");
            bus.io_read_req = 1'b0;
            step();
            step();
        end
        dc0 = done_cnt;
        bus.io_read_req = 1'b1;
        repeat (8) step();
        chk(done_cnt, dc0, "ovf_fifth_no_done");
        bus.io_read_req = 1'b0;
        chk(rx_q.size(), 0, "ovf_rxq_drained");
        pulse_clear();
        chk(32'(rx_overflow), 0, "ovf_cleared");

        // framing error: stop bit 0
        dc0 = done_cnt;
        send_rx(8'h33, 1'b0);
        repeat (4) step();
        chk(32'(rx_frame_err), 1, "ferr_set");
        bus.io_read_req = 1'b1;
        repeat (6) step();
        chk(done_cnt, dc0, "ferr_nothing_pushed");
        bus.io_read_req = 1'b0;
        pulse_clear();
        chk(32'(rx_frame_err), 0, "ferr_cleared");

        // one-cycle glitch, then a real frame still gets through
        dc0 = done_cnt;
        bus.io_read_req = 1'b1;
        uart_rxd = 1'b0;
        step();
        uart_rxd = 1'b1;
        repeat (20) step();
        chk(done_cnt, dc0, "glitch_no_push");
        chk(32'(rx_frame_err), 0, "glitch_no_err");
        bus.io_read_req = 1'b0;
        send_rx(8'hC3, 1'b1);
        repeat (4) step();
        bus.io_read_req = 1'b1;
        wait_done(10);
        chk(32'(bus.io_done), 1, "post_glitch_done");
        bus.io_read_req = 1'b0;
        step();

        // reset during TX data bit 3 of 0xF0 (bit 3 is 0)
        fr0 = tx_frames;
        bus.io_write_req = 1'b1;
        bus.io_wdata     = 8'hF0;
        tx_q.push_back(8'hF0);
        step();
        bus.io_write_req = 1'b0;
        repeat (18) step();
        chk(32'(uart_txd), 0, "rst_bit3_low");
        RSTN = 1'b0;
        #1;
        chk(32'(uart_txd), 1, "rst_txd_async_high");
        model_cnt = 0;
        rx_q.delete();
        repeat (2) step();
        chk(32'(bus.io_done), 0, "rst_done_low");
        RSTN = 1'b1;
        step();
        chk(32'(bus.io_ready), 1, "rst_ready_after");
        repeat (50) step();
        chk(32'(uart_txd), 1, "rst_line_idle");
        chk(tx_frames, fr0, "rst_no_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
